// File: rtl/switch_debounce.sv
// Purpose: synchronise a raw switch level and filter contact bounce into a clean level.
// Latency: a held change on i_level reaches o_db_level STABLE_CYCLES+2 edges later.
// Backpressure: none; free-running level conditioner that accepts every cycle.
module switch_debounce #(
    parameter int STABLE_CYCLES = 2_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_level,
    output logic       o_db_level,
    output logic [7:0] o_glitch_cnt
);

    // Counter just wide enough to hold STABLE_CYCLES-1, the countdown start value.
    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_CYCLES - 1);

    // ZERO/ONE are settled levels; WAIT1/WAIT0 are candidate transitions
    // towards 1 and 0 that still need the input to hold.
    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    logic             s1;
    logic             s2;
    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             glitch_inc;
    logic             db_nxt;

    // Two-flop synchroniser; only s2 is ever seen by the filter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= i_level;
            s2 <= s1;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ZERO;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, countdown and glitch detection. A reversal of s2 while
    // waiting wins over an expiring countdown, so a simultaneous event aborts.
    always_comb begin
        next_state = state;
        cnt_nxt    = cnt;
        glitch_inc = 1'b0;
        case (state)
            ZERO: begin
                if (s2) begin
                    next_state = WAIT1;
                    cnt_nxt    = CNT_LOAD;
                end
            end
            WAIT1: begin
                if (!s2) begin
                    next_state = ZERO;
                    glitch_inc = 1'b1;
                end else if (cnt == '0) begin
                    next_state = ONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ONE: begin
                if (!s2) begin
                    next_state = WAIT0;
                    cnt_nxt    = CNT_LOAD;
                end
            end
            WAIT0: begin
                if (s2) begin
                    next_state = ONE;
                    glitch_inc = 1'b1;
                end else if (cnt == '0) begin
                    next_state = ZERO;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                next_state = ZERO;
            end
        endcase
    end

    // Stability countdown; the decrement above is gated on nonzero so it never wraps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // Output level is 1 in ONE and WAIT0, so it only moves on a completed countdown.
    assign db_nxt = (next_state == ONE) || (next_state == WAIT0);

    // Registered debounced level, decoded from the next state so it lines up with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_db_level <= 1'b0;
        end else begin
            o_db_level <= db_nxt;
        end
    end

    // Saturating count of aborted transitions, held at 255 once reached.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_glitch_cnt <= 8'd0;
        end else if (glitch_inc && (o_glitch_cnt != 8'hFF)) begin
            o_glitch_cnt <= o_glitch_cnt + 8'd1;
        end
    end

endmodule
